// File: rtl/ctl_reg_loader.sv
// ctl_reg_loader: polls the controller BRAM flag word and streams requested register groups downstream.
// Define CTL_REG_LOADER_DEBUG_EN to also service the DEBUG_SET group (0xF0-0xF7) and drive dbg_update.
module ctl_reg_loader #(
    parameter int          READ_LATENCY  = 2,
    parameter logic [15:0] VERSION_MAJOR = 16'h00A2,
    parameter logic [15:0] VERSION_MINOR = 16'h0000
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic [7:0]  bram_addr,
    output logic        bram_we,
    output logic [15:0] bram_din,
    input  logic [15:0] bram_dout,
    input  logic [15:0] fpga_state,
    output logic [15:0] ctl_flag,
    output logic        cfg_valid,
    output logic [7:0]  cfg_addr,
    output logic [15:0] cfg_data,
    output logic        mod_update,
    output logic        stm_update,
    output logic        silencer_update,
    output logic        dbg_update
);

    // state      | meaning
    // INIT_MAJ   | write VERSION_MAJOR to 0x02
    // INIT_MIN   | write VERSION_MINOR to 0x03
    // POLL       | issue read of flag word 0x00
    // POLL_WAIT  | wait READ_LATENCY cycles for flag data
    // DECIDE     | latch flag, pick highest-priority group
    // LOAD       | issue one ascending read per cycle
    // DRAIN      | collect the trailing READ_LATENCY words
    // CLEAR      | write flag back with serviced bit zeroed, pulse update
    // STATE_WR   | write fpga_state to 0x01
    typedef enum logic [3:0] {
        S_INIT_MAJ, S_INIT_MIN, S_POLL, S_POLL_WAIT, S_DECIDE,
        S_LOAD, S_DRAIN, S_CLEAR, S_STATE_WR
    } state_t;

    localparam logic [4:0] RL_M1 = 5'(READ_LATENCY - 1);

    state_t      state_q, state_d;
    logic [4:0]  cnt_q, cnt_d;
    logic [7:0]  ld_addr_q, ld_addr_d;
    logic [3:0]  grp_q, grp_d;
    logic [15:0] clr_mask;

    logic [7:0]  addr_d;
    logic        we_d;
    logic [15:0] din_d;
    logic [15:0] flag_d;
    logic        ld_rd_d, ld_rd_q;
    logic [2:0]  upd_d, upd_q;

    logic [READ_LATENCY-1:0] pipe_vld;
    logic [7:0]              pipe_addr [READ_LATENCY];

    // grp one-hot: [0] MOD, [1] STM, [2] SILENCER, [3] DEBUG (flag bit 4)
    assign clr_mask = {11'b0, grp_q[3], 1'b0, grp_q[2:0]};

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        ld_addr_d = ld_addr_q;
        grp_d     = grp_q;
        flag_d    = ctl_flag;
        addr_d    = 8'h00;
        we_d      = 1'b0;
        din_d     = 16'h0000;
        ld_rd_d   = 1'b0;
        upd_d     = 3'b000;
        case (state_q)
            S_INIT_MAJ: begin
                addr_d  = 8'h02;
                we_d    = 1'b1;
                din_d   = VERSION_MAJOR;
                state_d = S_INIT_MIN;
            end
            S_INIT_MIN: begin
                addr_d  = 8'h03;
                we_d    = 1'b1;
                din_d   = VERSION_MINOR;
                state_d = S_POLL;
            end
            S_POLL: begin
                addr_d  = 8'h00;
                cnt_d   = RL_M1;
                state_d = S_POLL_WAIT;
            end
            S_POLL_WAIT: begin
                if (cnt_q == 5'd0) state_d = S_DECIDE;
                else               cnt_d   = cnt_q - 5'd1;
            end
            S_DECIDE: begin
                flag_d  = bram_dout;
                state_d = S_LOAD;
                if (bram_dout[0]) begin
                    grp_d = 4'b0001; ld_addr_d = 8'h20; cnt_d = 5'd12;
                end else if (bram_dout[1]) begin
                    grp_d = 4'b0010; ld_addr_d = 8'h50; cnt_d = 5'd19;
                end else if (bram_dout[2]) begin
                    grp_d = 4'b0100; ld_addr_d = 8'h40; cnt_d = 5'd4;
`ifdef CTL_REG_LOADER_DEBUG_EN
                end else if (bram_dout[4]) begin
                    grp_d = 4'b1000; ld_addr_d = 8'hF0; cnt_d = 5'd7;
`endif
                end else begin
                    grp_d   = 4'b0000;
                    state_d = S_STATE_WR;
                end
            end
            S_LOAD: begin
                addr_d    = ld_addr_q;
                ld_rd_d   = 1'b1;
                ld_addr_d = ld_addr_q + 8'd1;
                if (cnt_q == 5'd0) begin
                    cnt_d   = RL_M1;
                    state_d = S_DRAIN;
                end else begin
                    cnt_d = cnt_q - 5'd1;
                end
            end
            S_DRAIN: begin
                if (cnt_q == 5'd0) state_d = S_CLEAR;
                else               cnt_d   = cnt_q - 5'd1;
            end
            S_CLEAR: begin
                addr_d  = 8'h00;
                we_d    = 1'b1;
                din_d   = ctl_flag & ~clr_mask;
                upd_d   = grp_q[2:0];
                state_d = S_STATE_WR;
            end
            S_STATE_WR: begin
                addr_d  = 8'h01;
                we_d    = 1'b1;
                din_d   = fpga_state;
                state_d = S_POLL;
            end
            default: state_d = S_INIT_MAJ;
        endcase
    end

    // All BRAM-side outputs are registered so every output is 0 while in reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_INIT_MAJ;
            cnt_q     <= 5'd0;
            ld_addr_q <= 8'h00;
            grp_q     <= 4'b0000;
            bram_addr <= 8'h00;
            bram_we   <= 1'b0;
            bram_din  <= 16'h0000;
            ctl_flag  <= 16'h0000;
            ld_rd_q   <= 1'b0;
            upd_q     <= 3'b000;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            ld_addr_q <= ld_addr_d;
            grp_q     <= grp_d;
            bram_addr <= addr_d;
            bram_we   <= we_d;
            bram_din  <= din_d;
            ctl_flag  <= flag_d;
            ld_rd_q   <= ld_rd_d;
            upd_q     <= upd_d;
        end
    end

    // Stage 0 follows the presented address; the last stage lines up with its bram_dout.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < READ_LATENCY; i++) begin
                pipe_vld[i]  <= 1'b0;
                pipe_addr[i] <= 8'h00;
            end
        end else begin
            pipe_vld[0]  <= ld_rd_q;
            pipe_addr[0] <= bram_addr;
            for (int i = 1; i < READ_LATENCY; i++) begin
                pipe_vld[i]  <= pipe_vld[i-1];
                pipe_addr[i] <= pipe_addr[i-1];
            end
        end
    end

    assign cfg_valid       = pipe_vld[READ_LATENCY-1];
    assign cfg_addr        = cfg_valid ? pipe_addr[READ_LATENCY-1] : 8'h00;
    assign cfg_data        = cfg_valid ? bram_dout : 16'h0000;
    assign mod_update      = upd_q[0];
    assign stm_update      = upd_q[1];
    assign silencer_update = upd_q[2];

`ifdef CTL_REG_LOADER_DEBUG_EN
    logic dbg_q;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) dbg_q <= 1'b0;
        else        dbg_q <= (state_q == S_CLEAR) && grp_q[3];
    end
    assign dbg_update = dbg_q;
`else
    assign dbg_update = 1'b0;
`endif

endmodule

// File: tb/tb_ctl_reg_loader.sv
// tb_ctl_reg_loader: randomized scoreboard bench for ctl_reg_loader with a BRAM model and a
// group-servicing reference model; honours CTL_REG_LOADER_DEBUG_EN.
`timescale 1ns/1ps
module tb_ctl_reg_loader;
    localparam int RL = 2;
`ifdef CTL_REG_LOADER_DEBUG_EN
    localparam bit DBG_EN = 1'b1;
`else
    localparam bit DBG_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [7:0]  bram_addr;
    logic        bram_we;
    logic [15:0] bram_din;
    logic [15:0] bram_dout;
    logic [15:0] fpga_state;
    logic [15:0] ctl_flag;
    logic        cfg_valid;
    logic [7:0]  cfg_addr;
    logic [15:0] cfg_data;
    logic        mod_update, stm_update, silencer_update, dbg_update;

    ctl_reg_loader #(.READ_LATENCY(RL), .VERSION_MAJOR(16'h00A2), .VERSION_MINOR(16'h0000)) dut (
        .clk(clk), .rst_n(rst_n),
        .bram_addr(bram_addr), .bram_we(bram_we), .bram_din(bram_din), .bram_dout(bram_dout),
        .fpga_state(fpga_state), .ctl_flag(ctl_flag),
        .cfg_valid(cfg_valid), .cfg_addr(cfg_addr), .cfg_data(cfg_data),
        .mod_update(mod_update), .stm_update(stm_update),
        .silencer_update(silencer_update), .dbg_update(dbg_update)
    );

    always #5 clk = ~clk;

    // BRAM: read data of the address presented in cycle a appears in cycle a+RL.
    logic [15:0] mem [256];
    logic [15:0] rd_pipe [RL];
    assign bram_dout = rd_pipe[RL-1];
    always @(posedge clk) begin
        rd_pipe[0] <= mem[bram_addr];
        for (int i = 1; i < RL; i++) rd_pipe[i] <= rd_pipe[i-1];
        if (bram_we) mem[bram_addr] = bram_din;
    end

    typedef struct { logic [7:0] addr; logic [15:0] data; bit last; logic [3:0] mask; } cfg_t;
    typedef struct { logic [15:0] pre; logic [15:0] post; int n; } flg_t;
    cfg_t exp_cfg[$];
    flg_t exp_flg[$];

    int vectors = 0;
    int miscompares = 0;

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endfunction

    function automatic logic [3:0] upd_mask(input int bitn);
        return (bitn == 4) ? 4'b1000 : 4'(1 << bitn);
    endfunction

    // Reference model: service groups in priority order until none is requested.
    task automatic push_expected(input logic [15:0] flag_in, output logic [15:0] flag_out);
        logic [15:0] f;
        int base, n, bitn;
        bit found;
        f = flag_in;
        base = 0; n = 0; bitn = 0;
        do begin
            found = 1'b1;
            if (f[0])                begin bitn = 0; base = 'h20; n = 13; end
            else if (f[1])           begin bitn = 1; base = 'h50; n = 20; end
            else if (f[2])           begin bitn = 2; base = 'h40; n = 5;  end
            else if (DBG_EN && f[4]) begin bitn = 4; base = 'hF0; n = 8;  end
            else found = 1'b0;
            if (found) begin
                for (int i = 0; i < n; i++)
                    exp_cfg.push_back('{addr: 8'(base + i), data: mem[base + i],
                                        last: (i == n - 1), mask: upd_mask(bitn)});
                exp_flg.push_back('{pre: f, post: f & ~(16'h1 << bitn), n: n});
                f = f & ~(16'h1 << bitn);
            end
        end while (found);
        flag_out = f;
    endtask

    // Monitor / scoreboard
    logic        pend_upd = 1'b0;
    logic [3:0]  pend_mask = 4'b0;
    bit          in_burst = 1'b0;
    int          wr_idx = 0;
    int          cyc = 0;
    int          anchor = -1;
    int          served_n = 0;
    int          cfg_seen = 0;
    int          n_state_wr = 0;
    logic [15:0] fs_at_edge;
    always @(posedge clk) fs_at_edge <= fpga_state;

    always @(negedge clk) begin
        logic [3:0] upd;
        bit upd_now;
        cfg_t e;
        flg_t f;
        cyc++;
        if (!rst_n) begin
            pend_upd = 1'b0; in_burst = 1'b0; wr_idx = 0; anchor = -1; served_n = 0;
        end else begin
            upd = {dbg_update, silencer_update, stm_update, mod_update};
            upd_now = pend_upd;
            if (pend_upd) begin
                chk("update_pulse", 32'(upd), 32'(pend_mask));
                pend_upd = 1'b0;
            end else if (upd != 4'b0) begin
                chk("spurious_update", 32'(upd), 32'h0);
            end
            if (cfg_valid) begin
                if (exp_cfg.size() == 0) begin
                    chk("cfg_unexpected", {8'h0, cfg_addr, cfg_data}, 32'h0);
                end else begin
                    e = exp_cfg.pop_front();
                    chk("cfg_addr", 32'(cfg_addr), 32'(e.addr));
                    chk("cfg_data", 32'(cfg_data), 32'(e.data));
                    cfg_seen++;
                    in_burst = !e.last;
                    if (e.last) begin pend_upd = 1'b1; pend_mask = e.mask; end
                end
            end else if (in_burst) begin
                chk("burst_gap", 32'(cfg_valid), 32'h1);
                in_burst = 1'b0;
            end
            if (bram_we) begin
                if (wr_idx == 0) begin
                    chk("ver_major_addr", 32'(bram_addr), 32'h02);
                    chk("ver_major_data", 32'(bram_din), 32'h00A2);
                end else if (wr_idx == 1) begin
                    chk("ver_minor_addr", 32'(bram_addr), 32'h03);
                    chk("ver_minor_data", 32'(bram_din), 32'h0000);
                    anchor = cyc;
                end else if (bram_addr == 8'h00) begin
                    chk("clear_with_update", 32'(upd_now), 32'h1);
                    if (exp_flg.size() == 0) begin
                        chk("flag_wb_unexpected", 32'(bram_din), 32'hFFFF_FFFF);
                    end else begin
                        f = exp_flg.pop_front();
                        chk("flag_writeback", 32'(bram_din), 32'(f.post));
                        chk("ctl_flag_at_clear", 32'(ctl_flag), 32'(f.pre));
                        served_n = f.n;
                    end
                end else if (bram_addr == 8'h01) begin
                    chk("state_write", 32'(bram_din), 32'(fs_at_edge));
                    if (anchor >= 0)
                        chk("loop_period", 32'(cyc - anchor),
                            (served_n != 0) ? 32'(2 * RL + served_n + 4) : 32'(RL + 3));
                    anchor = cyc;
                    served_n = 0;
                    n_state_wr++;
                end else begin
                    chk("write_addr", 32'(bram_addr), 32'h01);
                end
                wr_idx++;
            end
        end
    end

    task automatic host_wr(input logic [7:0] a, input logic [15:0] d);
        mem[a] = d;
    endtask

    task automatic rand_groups();
        for (int a = 'h20; a <= 'h2C; a++) mem[a] = 16'($urandom);
        for (int a = 'h40; a <= 'h44; a++) mem[a] = 16'($urandom);
        for (int a = 'h50; a <= 'h63; a++) mem[a] = 16'($urandom);
        for (int a = 'hF0; a <= 'hF7; a++) mem[a] = 16'($urandom);
    endtask

    task automatic wait_idle(input int budget, input string name);
        int c;
        c = 0;
        while ((exp_cfg.size() != 0 || exp_flg.size() != 0 || pend_upd) && c < budget) begin
            @(negedge clk); #1;
            c++;
        end
        chk({name, "_drained"}, 32'(exp_cfg.size() + exp_flg.size() + int'(pend_upd)), 32'h0);
        repeat (4) @(negedge clk);
        #1;
    endtask

    task automatic wait_poll();
        repeat (2 * (RL + 3)) @(negedge clk);
        #1;
    endtask

    initial begin
        logic [15:0] fin;
        int start, c;
        for (int i = 0; i < 256; i++) mem[i] = 16'h0000;
        fpga_state = 16'h0000;
        rst_n = 1'b0;
        repeat (3) @(negedge clk); #1;
        chk("reset_outputs_zero",
            32'(|{bram_addr, bram_we, bram_din, ctl_flag, cfg_valid, cfg_addr, cfg_data,
                  mod_update, stm_update, silencer_update, dbg_update}), 32'h0);

        // Idle polling with flag 0
        fpga_state = 16'($urandom);
        n_state_wr = 0;
        rst_n = 1'b1;
        repeat (8 * (RL + 3)) @(negedge clk); #1;
        chk("idle_state_writes", 32'(n_state_wr >= 6), 32'h1);
        chk("idle_ctl_flag", 32'(ctl_flag), 32'h0);

        // Modulation group with known contents
        for (int a = 'h20; a <= 'h2C; a++) mem[a] = 16'(16'h1000 + a);
        push_expected(16'h0001, fin);
        host_wr(8'h00, 16'h0001);
        wait_idle(300, "mod");
        chk("mod_flag_mem", 32'(mem[0]), 32'(fin));
        wait_poll();
        chk("mod_ctl_flag_after", 32'(ctl_flag), 32'(fin));

        // Three groups serviced on successive loops
        rand_groups();
        fpga_state = 16'($urandom);
        push_expected(16'h0007, fin);
        host_wr(8'h00, 16'h0007);
        wait_idle(600, "three_groups");
        chk("three_flag_mem", 32'(mem[0]), 32'(fin));

        // STM with sticky bits left alone
        rand_groups();
        push_expected(16'h2012, fin);
        host_wr(8'h00, 16'h2012);
        wait_idle(300, "stm_sticky");
        chk("stm_flag_mem", 32'(mem[0]), 32'(fin));
        wait_poll();
        chk("stm_ctl_flag_after", 32'(ctl_flag), 32'(fin));
        host_wr(8'h00, 16'h0000);
        wait_poll();

        // Reset after the 6th MOD CFG_VALID
        rand_groups();
        push_expected(16'h0001, fin);
        start = cfg_seen;
        host_wr(8'h00, 16'h0001);
        c = 0;
        while (cfg_seen < start + 6 && c < 300) begin @(negedge clk); #1; c++; end
        chk("reset_reached_6th", 32'(cfg_seen - start), 32'd6);
        rst_n = 1'b0;
        #1;
        chk("abort_outputs_zero",
            32'(|{bram_addr, bram_we, bram_din, ctl_flag, cfg_valid, cfg_addr, cfg_data,
                  mod_update, stm_update, silencer_update, dbg_update}), 32'h0);
        exp_cfg.delete();
        exp_flg.delete();
        repeat (2) @(negedge clk); #1;
        push_expected(16'h0001, fin);
        rst_n = 1'b1;
        wait_idle(300, "reset_reservice");
        chk("reset_flag_mem", 32'(mem[0]), 32'(fin));

        // DEBUG group request
        rand_groups();
        push_expected(16'h0010, fin);
        host_wr(8'h00, 16'h0010);
        wait_idle(300, "debug");
        wait_poll();
        chk("debug_flag_mem", 32'(mem[0]), DBG_EN ? 32'h0 : 32'h0010);
        chk("debug_ctl_flag", 32'(ctl_flag), DBG_EN ? 32'h0 : 32'h0010);
        host_wr(8'h00, 16'h0000);
        wait_poll();

        // Random flag words
        for (int it = 0; it < 12; it++) begin
            logic [15:0] f;
            rand_groups();
            f = 16'($urandom);
            fpga_state = 16'($urandom);
            push_expected(f, fin);
            host_wr(8'h00, f);
            wait_idle(800, "random");
            wait_poll();
            chk("rand_flag_mem", 32'(mem[0]), 32'(fin));
            chk("rand_ctl_flag", 32'(ctl_flag), 32'(fin));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

endmodule
